// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder controller.
// State encoding: IDLE=0, RUN=1, DONE=2; the unused code 3 recovers to IDLE.
package serial_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned DEFAULT_WIDTH = 8;

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell; the controller's only arithmetic element.
module full_adder (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_sum,
    output logic o_cout
);

    assign o_sum  = i_a ^ i_b ^ i_cin;
    assign o_cout = (i_a & i_b) | (i_a & i_cin) | (i_b & i_cin);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one full_adder cell reused across WIDTH
// clocks, LSB first, with valid/ready handshakes on operands and result.
// Optional macro SERIAL_ADD_SUB_EN adds a 'sub' input (a-b in two's
// complement) and an 'ovf' signed-overflow output.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             sub,
    output logic             ovf,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int unsigned      CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic [CNT_W-1:0] r_cnt;
    logic             w_accept;
    logic             w_step;
    logic             w_last;
    logic             w_fa_sum;
    logic             w_fa_cout;
`ifdef SERIAL_ADD_SUB_EN
    logic             r_ovf;
`endif

    full_adder u_fa (
        .i_a    (r_a[0]),
        .i_b    (r_b[0]),
        .i_cin  (r_carry),
        .o_sum  (w_fa_sum),
        .o_cout (w_fa_cout)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and handshake outputs
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        busy        = 1'b0;
        w_accept    = 1'b0;
        w_step      = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                busy   = 1'b1;
                w_step = 1'b1;
                if (r_cnt == LAST) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_last = w_step && (r_cnt == LAST);

    // Operand load on accept, then one bit per clock through the adder cell
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
`ifdef SERIAL_ADD_SUB_EN
            r_ovf   <= 1'b0;
`endif
        end else if (w_accept) begin
            r_a   <= a;
            r_cnt <= '0;
`ifdef SERIAL_ADD_SUB_EN
            r_b     <= sub ? ~b : b;
            r_carry <= sub ? 1'b1 : cin;
`else
            r_b     <= b;
            r_carry <= cin;
`endif
        end else if (w_step) begin
            r_a     <= r_a >> 1;
            r_b     <= r_b >> 1;
            r_sum   <= {w_fa_sum, r_sum[WIDTH-1:1]};
            r_carry <= w_fa_cout;
            // Counter parks at WIDTH-1 on the last bit instead of wrapping.
            if (!w_last) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
`ifdef SERIAL_ADD_SUB_EN
            if (w_last) begin
                r_ovf <= r_carry ^ w_fa_cout;
            end
`endif
        end
    end

    assign sum  = r_sum;
    assign cout = r_carry;
`ifdef SERIAL_ADD_SUB_EN
    assign ovf  = r_ovf;
`endif

endmodule
